// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the integer register file.
package regfile_pkg;

  localparam int DEF_XLEN = 64;
  localparam int DEF_NREG = 32;
  localparam int DEF_AW   = $clog2(DEF_NREG);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one busy bit per register and a running count of
// busy registers. A reserve beats a same-cycle clear on the same register
// because the reserve belongs to a newer load. Register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     pend_cnt
);

  logic rsvHit;
  logic wbHit;
  logic setEv;
  logic clrEv;

  assign rsvHit = rsv_en && (rsv_addr != '0);
  assign wbHit  = wb_en  && (wb_addr  != '0);

  // A set or clear only counts when the bit actually changes, so the count
  // tracks the population of the busy vector without a full popcount.
  assign setEv = rsvHit && !busy[rsv_addr];
  assign clrEv = wbHit && busy[wb_addr] && !(rsvHit && (rsv_addr == wb_addr));

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : gBit
    // Per-register busy flop: reserve has priority over clear, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        busy[r] <= 1'b0;
      else if (rsvHit && (rsv_addr == AW'(r)))
        busy[r] <= 1'b1;
      else if (wbHit && (wb_addr == AW'(r)))
        busy[r] <= 1'b0;
    end
  end

  // Incremental population count of the busy vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend_cnt <= '0;
    else begin
      case ({setEv, clrEv})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with ALU (port A) and load (port B) writeback and a
// pending-load scoreboard. Register 0 reads zero and is never written.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and clears to reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic [AW:0]     pend_cnt
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;
  logic [1:0][AW-1:0]        rdAddr;
  logic [1:0][XLEN-1:0]      rdData;
  logic [1:0]                rdBusy;

  regfile_scoreboard #(.NREG(NREG), .AW(AW)) uSb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .pend_cnt (pend_cnt)
  );

  // Data array: port B is applied after port A so a load wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      regs <= '0;
    else begin
      if (wa_en && (wa_addr != '0)) regs[wa_addr] <= wa_data;
      if (wb_en && (wb_addr != '0)) regs[wb_addr] <= wb_data;
    end
  end

  assign rdAddr = {rs2_addr, rs1_addr};

  for (genvar p = 0; p < 2; p++) begin : gRd
    // Read port mux: zero register, optional forwarding, then stored state.
    always_comb begin
      rdData[p] = regs[rdAddr[p]];
      rdBusy[p] = busy[rdAddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wb_en && (wb_addr == rdAddr[p])) begin
        rdData[p] = wb_data;
        if (!(rsv_en && (rsv_addr == rdAddr[p]))) rdBusy[p] = 1'b0;
      end else if (wa_en && (wa_addr == rdAddr[p])) begin
        rdData[p] = wa_data;
      end
`endif
      if (rdAddr[p] == ZERO_REG[AW-1:0]) begin
        rdData[p] = '0;
        rdBusy[p] = 1'b0;
      end
    end
  end

  assign rs1_data = rdData[0];
  assign rs2_data = rdData[1];
  assign rs1_busy = rdBusy[0];
  assign rs2_busy = rdBusy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed checks of regfile_sb against an array-based model.
module tb_regfile_sb;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, wa_addr, wb_addr, rsv_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, wa_data, wb_data;
  logic            rs1_busy, rs2_busy, wa_en, wb_en, rsv_en;
  logic [AW:0]     pend_cnt;

  int errs   = 0;
  int checks = 0;

  logic [XLEN-1:0] mMem  [NREG];
  bit              mBusy [NREG];

  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] expData(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
    if (wa_en && wa_addr == a) return wa_data;
`endif
    return mMem[a];
  endfunction

  function automatic logic expBusy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_addr == a && !(rsv_en && rsv_addr == a)) return 1'b0;
`endif
    return mBusy[a];
  endfunction

  function automatic int expCnt();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(mBusy[i]);
    return n;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NREG; i++) begin
      mMem[i]  = '0;
      mBusy[i] = 1'b0;
    end
  endfunction

  // Drive one cycle of inputs, check combinational reads, clock, update model.
  task automatic step(input bit wae, input int waa, input logic [63:0] wad,
                      input bit wbe, input int wba, input logic [63:0] wbd,
                      input bit rse, input int rsa, input int r1, input int r2);
    wa_en = wae; wa_addr = AW'(waa); wa_data = wad;
    wb_en = wbe; wb_addr = AW'(wba); wb_data = wbd;
    rsv_en = rse; rsv_addr = AW'(rsa);
    rs1_addr = AW'(r1); rs2_addr = AW'(r2);
    #1;
    chk("rs1_data", rs1_data, expData(rs1_addr));
    chk("rs2_data", rs2_data, expData(rs2_addr));
    chk("rs1_busy", 64'(rs1_busy), 64'(expBusy(rs1_addr)));
    chk("rs2_busy", 64'(rs2_busy), 64'(expBusy(rs2_addr)));
    chk("pend_cnt", 64'(pend_cnt), 64'(expCnt()));
    @(posedge clk);
    if (wa_en && wa_addr != 0) mMem[wa_addr] = wa_data;
    if (wb_en && wb_addr != 0) mMem[wb_addr] = wb_data;
    if (wb_en && wb_addr != 0) mBusy[wb_addr] = 1'b0;
    if (rsv_en && rsv_addr != 0) mBusy[rsv_addr] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int r1, input int r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  function automatic int rAddr();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    rst_n = 1'b0;
    wa_en = 0; wb_en = 0; rsv_en = 0;
    wa_addr = 0; wb_addr = 0; rsv_addr = 0; rs1_addr = 0; rs2_addr = 0;
    wa_data = 0; wb_data = 0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state: every address reads zero, not busy.
    for (int i = 0; i < NREG; i += 2) idle(i, i + 1);

    // Zero register ignores writes and reserves.
    step(1, 0, 64'hDEAD, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("x0_data", rs1_data, 64'h0);
    chk("x0_cnt", 64'(pend_cnt), 64'h0);

    // Port A write and read-after-write.
    step(1, 5, 64'h1234, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);
    #1; chk("x5_data", rs1_data, 64'h1234);

    // Port collision: port B wins.
    step(1, 7, 64'hAAAA, 1, 7, 64'hBBBB, 0, 0, 0, 0);
    #1; rs1_addr = 7; #1; chk("x7_data", rs1_data, 64'hBBBB);

    // Reserve then load return.
    step(0, 0, 0, 0, 0, 0, 1, 3, 0, 3);
    #1; chk("x3_busy", 64'(rs2_busy), 64'h1);
    chk("x3_cnt", 64'(pend_cnt), 64'h1);
    step(0, 0, 0, 1, 3, 64'h55, 0, 0, 3, 3);
    #1; chk("x3_clr", 64'(rs2_busy), 64'h0);
    chk("x3_data", rs2_data, 64'h55);
    chk("x3_cnt0", 64'(pend_cnt), 64'h0);

    // Reserve wins over same-cycle clear; re-reserve keeps count.
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 0, 0, 1, 9, 64'h99, 1, 9, 9, 0);
    #1; chk("x9_busy", 64'(rs1_busy), 64'h1);
    chk("x9_cnt", 64'(pend_cnt), 64'h1);
    step(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    #1; chk("x4_cnt", 64'(pend_cnt), 64'h2);

    // Fill the scoreboard, then reset asynchronously mid-sequence.
    for (int i = 1; i < NREG; i++) step(0, 0, 0, 0, 0, 0, 1, i, i, 0);
    #1; chk("full_cnt", 64'(pend_cnt), 64'(NREG - 1));
    rsv_en = 1; rsv_addr = 12; rs1_addr = 12; rs2_addr = 5;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(pend_cnt), 64'h0);
    chk("arst_busy", 64'(rs1_busy), 64'h0);
    chk("arst_data", rs2_data, 64'h0);
    modelReset();
    @(posedge clk); #1;
    chk("arst_hold", 64'(pend_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with address collisions.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 1), rAddr(), {$urandom, $urandom},
           $urandom_range(0, 2) == 0, rAddr(), {$urandom, $urandom},
           $urandom_range(0, 2) == 0, rAddr(), rAddr(), rAddr());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
